// File: rtl/tcdm_bank_pkg.sv
// Shared types and helpers for the TCDM bank responder: FSM states, request payload (un)packing, byte merge.
// Latency: n/a (combinational functions only).
// Backpressure: n/a.
package tcdm_bank_pkg;

    localparam int unsigned MaxDataWidth = 512;
    localparam int unsigned MaxBeWidth   = MaxDataWidth / 8;
    localparam int unsigned MaxReqWidth  = 1 + MaxBeWidth + MaxDataWidth;

    typedef enum logic {
        IDLE,
        RMW_WR
    } state_e;

    typedef struct packed {
        logic                    wen;
        logic [MaxBeWidth-1:0]   be;
        logic [MaxDataWidth-1:0] wdata;
    } payload_t;

    // Payload layout on the wire is {wen, be[dw/8-1:0], wdata[dw-1:0]}, LSB-aligned.
    function automatic payload_t unpack_payload(input logic [MaxReqWidth-1:0] raw,
                                                input int unsigned             dw);
        payload_t                p;
        logic [MaxDataWidth-1:0] dmask;
        logic [MaxBeWidth-1:0]   bmask;
        dmask   = {MaxDataWidth{1'b1}} >> (MaxDataWidth - dw);
        bmask   = {MaxBeWidth{1'b1}} >> (MaxBeWidth - dw / 8);
        p.wdata = MaxDataWidth'(raw) & dmask;
        p.be    = MaxBeWidth'(raw >> dw) & bmask;
        p.wen   = 1'(raw >> (dw + dw / 8));
        return p;
    endfunction

    function automatic logic [MaxReqWidth-1:0] pack_payload(input payload_t    p,
                                                            input int unsigned dw);
        logic [MaxDataWidth-1:0] dmask;
        logic [MaxBeWidth-1:0]   bmask;
        dmask = {MaxDataWidth{1'b1}} >> (MaxDataWidth - dw);
        bmask = {MaxBeWidth{1'b1}} >> (MaxBeWidth - dw / 8);
        return (MaxReqWidth'(p.wen) << (dw + dw / 8))
             | (MaxReqWidth'(p.be & bmask) << dw)
             | MaxReqWidth'(p.wdata & dmask);
    endfunction

    function automatic logic [MaxDataWidth-1:0] merge_bytes(input logic [MaxDataWidth-1:0] old_word,
                                                            input logic [MaxDataWidth-1:0] new_word,
                                                            input logic [MaxBeWidth-1:0]   be);
        logic [MaxDataWidth-1:0] mask;
        logic                    sel;
        mask = '0;
        for (int b = 0; b < MaxBeWidth; b++) begin
            sel = 1'(be >> b);
            if (sel) mask = mask | (MaxDataWidth'(8'hFF) << (8 * b));
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/tcdm_sram_sp.sv
// Single-port word array, one read or full-word write per cycle.
// Latency: read data registered, valid the cycle after req with we low; holds otherwise.
// Backpressure: none; accepts an access every cycle.
module tcdm_sram_sp #(
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned NumWords  = 256,
    localparam int unsigned AddrWidth = $clog2(NumWords)
) (
    input  logic                 clk,
    input  logic                 req,
    input  logic                 we,
    input  logic [AddrWidth-1:0] addr,
    input  logic [DataWidth-1:0] wdata,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] mem [NumWords];

    always_ff @(posedge clk) begin
        if (req) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/tcdm_bank_responder.sv
// TCDM bank slave: grants requests, serves reads, and emulates byte-enable writes with read-modify-write.
// Latency: response one cycle after grant; a partial write adds one non-granting cycle.
// Backpressure: gnt_o drops on stall_i or while the merge write occupies the array; no response backpressure.
module tcdm_bank_responder
    import tcdm_bank_pkg::*;
#(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumWords      = 256,
    parameter int unsigned AddWidth      = 5,
    parameter int unsigned ReqDataWidth  = 1 + DataWidth / 8 + DataWidth,
    parameter int unsigned RespDataWidth = DataWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic [AddWidth-1:0]      add_i,
    input  logic [ReqDataWidth-1:0]  data_i,
    output logic [RespDataWidth-1:0] rdata_o,
    input  logic                     stall_i
);

    localparam int unsigned IdxWidth = $clog2(NumWords);
    localparam int unsigned BeWidth  = DataWidth / 8;

    state_e                        state_q, state_d;
    payload_t                      req_pl;
    logic [IdxWidth+AddWidth-1:0]  add_ext;
    logic [IdxWidth-1:0]           req_idx, rmw_idx_q, mem_addr;
    logic [BeWidth-1:0]            req_be, rmw_be_q;
    logic [DataWidth-1:0]          req_wdata, rmw_wdata_q, mem_wdata, mem_rdata;
    logic [MaxDataWidth-1:0]       merged;
    logic                          gnt, mem_req, mem_we, rmw_start, rd_vld_q;
    logic                          be_full, be_none;
    logic                          unused_bits;

    // Zero-extend first so the index slice is legal even when AddWidth is narrower than the index.
    assign add_ext   = {{IdxWidth{1'b0}}, add_i};
    assign req_idx   = add_ext[IdxWidth-1:0];
    assign req_pl    = unpack_payload(MaxReqWidth'(data_i), DataWidth);
    assign req_be    = req_pl.be[BeWidth-1:0];
    assign req_wdata = req_pl.wdata[DataWidth-1:0];
    assign be_full   = (req_be == {BeWidth{1'b1}});
    assign be_none   = (req_be == '0);

    // Old word comes straight from the array output, read in the granting cycle.
    assign merged = merge_bytes(MaxDataWidth'(mem_rdata), MaxDataWidth'(rmw_wdata_q),
                                MaxBeWidth'(rmw_be_q));

    assign unused_bits = ^{add_ext, req_pl, merged};

    always_comb begin
        state_d   = state_q;
        gnt       = 1'b0;
        rmw_start = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = req_idx;
        mem_wdata = req_wdata;
        unique case (state_q)
            IDLE: begin
                gnt = req_i & ~stall_i & ~rst_i;
                if (gnt) begin
                    if (!req_pl.wen) begin
                        mem_req = 1'b1;
                    end else if (be_full) begin
                        mem_req = 1'b1;
                        mem_we  = 1'b1;
                    end else if (!be_none) begin
                        mem_req   = 1'b1;
                        rmw_start = 1'b1;
                        state_d   = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                // stall_i does not hold off the merge; only reset aborts it.
                mem_req   = ~rst_i;
                mem_we    = 1'b1;
                mem_addr  = rmw_idx_q;
                mem_wdata = merged[DataWidth-1:0];
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rd_vld_q    <= 1'b0;
            rmw_idx_q   <= '0;
            rmw_be_q    <= '0;
            rmw_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= gnt & ~req_pl.wen;
            if (rmw_start) begin
                rmw_idx_q   <= req_idx;
                rmw_be_q    <= req_be;
                rmw_wdata_q <= req_wdata;
            end
        end
    end

    tcdm_sram_sp #(
        .DataWidth (DataWidth),
        .NumWords  (NumWords)
    ) u_sram (
        .clk   (clk_i),
        .req   (mem_req),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign gnt_o   = gnt;
    assign rdata_o = (rd_vld_q && !rst_i) ? RespDataWidth'(mem_rdata) : '0;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: directed scenarios plus random traffic against a word-array reference model.
module tb_tcdm_bank_responder;

    localparam int DW  = 32;
    localparam int NW  = 16;
    localparam int AW  = 5;
    localparam int RQW = 1 + DW / 8 + DW;

    logic           clk = 1'b0;
    logic           rst, req, stall, gnt;
    logic [AW-1:0]  add;
    logic [RQW-1:0] data;
    logic [DW-1:0]  rdata;

    always #5 clk = ~clk;

    tcdm_bank_responder #(
        .DataWidth     (DW),
        .NumWords      (NW),
        .AddWidth      (AW),
        .ReqDataWidth  (RQW),
        .RespDataWidth (DW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .gnt_o   (gnt),
        .add_i   (add),
        .data_i  (data),
        .rdata_o (rdata),
        .stall_i (stall)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: the bank contents plus at most one merge write owed to the next cycle.
    logic [DW-1:0] mem_m [NW];
    bit            pend = 0;
    int            pend_idx;
    logic [DW-1:0] pend_val;
    logic [DW-1:0] last_rdata;
    logic          last_gnt;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge_ref(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                                input logic [3:0] be);
        logic [DW-1:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] byte_v;
            byte_v = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
            r[8*i +: 8] = byte_v;
        end
        return r;
    endfunction

    task automatic cycle(input string tag, input bit r, input bit st, input bit rs,
                         input logic [AW-1:0] a, input bit wen, input logic [3:0] be,
                         input logic [DW-1:0] wd);
        bit            exp_g;
        logic [DW-1:0] exp_r;
        int            idx;
        @(negedge clk);
        rst   = rs;
        req   = r;
        stall = st;
        add   = a;
        data  = {wen, be, wd};
        #1;
        exp_g    = !rs && !pend && r && !st;
        last_gnt = gnt;
        check({tag, ".gnt"}, DW'(gnt), DW'(exp_g));
        idx   = int'(a) % NW;
        exp_r = '0;
        if (pend && !rs) mem_m[pend_idx] = pend_val;
        pend = 0;
        if (exp_g) begin
            if (!wen) begin
                exp_r = mem_m[idx];
            end else if (be == 4'hF) begin
                mem_m[idx] = wd;
            end else if (be != 4'h0) begin
                pend     = 1;
                pend_idx = idx;
                pend_val = merge_ref(mem_m[idx], wd, be);
            end
        end
        @(posedge clk);
        #1;
        last_rdata = rdata;
        check({tag, ".rdata"}, rdata, exp_r);
    endtask

    initial begin
        rst   = 1'b1;
        req   = 1'b0;
        stall = 1'b0;
        add   = '0;
        data  = '0;

        // Reset with a live request: no grant, no response.
        cycle("rst_a", 1, 0, 1, 5'd1, 0, 4'h0, 32'h0);
        cycle("rst_b", 1, 0, 1, 5'd2, 1, 4'hF, 32'h12345678);

        for (int i = 0; i < NW; i++) cycle("fill", 1, 0, 0, 5'(i), 1, 4'hF, $urandom);

        // Full write then read.
        cycle("fw3", 1, 0, 0, 5'd3, 1, 4'hF, 32'hDEADBEEF);
        check("fw3_gnt", DW'(last_gnt), 32'd1);
        cycle("rd3", 1, 0, 0, 5'd3, 0, 4'h0, 32'h0);
        check("rd3_gnt", DW'(last_gnt), 32'd1);
        check("rd3_val", last_rdata, 32'hDEADBEEF);

        // Partial write, the following cycle must not grant, then read back the merge.
        cycle("fw5", 1, 0, 0, 5'd5, 1, 4'hF, 32'h11223344);
        cycle("pw5", 1, 0, 0, 5'd5, 1, 4'b0101, 32'hAABBCCDD);
        cycle("pw5_hole", 1, 0, 0, 5'd5, 0, 4'h0, 32'h0);
        check("pw5_hole_gnt", DW'(last_gnt), 32'd0);
        cycle("rd5", 1, 0, 0, 5'd5, 0, 4'h0, 32'h0);
        check("rd5_val", last_rdata, 32'h11BB33DD);

        // Stall holds off grants; grant on the first cycle it drops.
        for (int i = 0; i < 3; i++) cycle("stall", 1, 1, 0, 5'd3, 0, 4'h0, 32'h0);
        cycle("stall_rel", 1, 0, 0, 5'd3, 0, 4'h0, 32'h0);
        check("stall_rel_gnt", DW'(last_gnt), 32'd1);

        // Stall during the merge cycle does not delay the merge.
        cycle("fw9", 1, 0, 0, 5'd9, 1, 4'hF, 32'h01020304);
        cycle("pw9", 1, 0, 0, 5'd9, 1, 4'b1000, 32'h55000000);
        cycle("pw9_stall", 1, 1, 0, 5'd9, 0, 4'h0, 32'h0);
        cycle("rd9", 1, 0, 0, 5'd9, 0, 4'h0, 32'h0);
        check("rd9_val", last_rdata, 32'h55020304);

        // Reset in the merge cycle aborts the merge.
        cycle("fw7", 1, 0, 0, 5'd7, 1, 4'hF, 32'h0);
        cycle("pw7", 1, 0, 0, 5'd7, 1, 4'b0001, 32'h000000FF);
        cycle("pw7_rst", 1, 0, 1, 5'd7, 0, 4'h0, 32'h0);
        check("pw7_rst_gnt", DW'(last_gnt), 32'd0);
        check("pw7_rst_rdata", last_rdata, 32'h0);
        cycle("rd7", 1, 0, 0, 5'd7, 0, 4'h0, 32'h0);
        check("rd7_val", last_rdata, 32'h0);

        // Upper address bits are ignored.
        cycle("fw2", 1, 0, 0, 5'd2, 1, 4'hF, 32'hCAFEF00D);
        cycle("rd18", 1, 0, 0, 5'b10010, 0, 4'h0, 32'h0);
        check("rd18_val", last_rdata, 32'hCAFEF00D);

        // Be=0 write: granted, no merge cycle, no array change.
        cycle("be0", 1, 0, 0, 5'd2, 1, 4'h0, 32'h99999999);
        cycle("be0_next", 1, 0, 0, 5'd2, 0, 4'h0, 32'h0);
        check("be0_next_gnt", DW'(last_gnt), 32'd1);
        check("be0_val", last_rdata, 32'hCAFEF00D);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cycle("rand",
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 39) == 0,
                  5'($urandom),
                  1'($urandom),
                  4'($urandom),
                  $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
